// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller
// AHB-slave-side bridge controller. Decodes AHB transfers aimed at three
// APB slaves, sequences the APB SETUP/ACCESS phases one transfer at a time
// and stalls the AHB master through Hreadyout while an APB transfer runs.

module apb_fsm_controller #(
   parameter logic [5:0] SLV0_BASE = 6'h20,
   parameter logic [5:0] SLV1_BASE = 6'h21,
   parameter logic [5:0] SLV2_BASE = 6'h22
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic        Hwrite,
   input  logic        Hreadyin,
   input  logic [1:0]  Htrans,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic [31:0] Prdata,
   output logic        Pwrite,
   output logic        Penable,
   output logic [2:0]  Pselx,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   output logic        Hreadyout,
   output logic [1:0]  Hresp,
   output logic [31:0] Hrdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      RENABLE = 3'd2,
      WWAIT   = 3'd3,
      WRITE   = 3'd4,
      WENABLE = 3'd5
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [2:0]  selx;
   logic        valid;
   logic [2:0]  pselx_q;
   logic        penable_q;
   logic        pwrite_q;
   logic [31:0] paddr_q;
   logic [31:0] pwdata_q;
   logic        hreadyout_q;
   logic [31:0] addrHold_q;
   logic [2:0]  selHold_q;

   // Htrans[0] only separates NONSEQ from SEQ (and IDLE from BUSY); both
   // members of each pair are treated alike, so that bit is not needed.
   logic        unusedHtrans0;
   assign unusedHtrans0 = Htrans[0];

   // Address decode: one-hot slave select from the top six address bits,
   // and a transfer is only worth acting on when it is active and hits a slave.
   always_comb begin
      selx = 3'b000;
      if (Haddr[31:26] == SLV0_BASE) selx[0] = 1'b1;
      if (Haddr[31:26] == SLV1_BASE) selx[1] = 1'b1;
      if (Haddr[31:26] == SLV2_BASE) selx[2] = 1'b1;
      valid = Hreadyin & Htrans[1] & (selx != 3'b000);
   end

   // Next-state logic: new transfers are only accepted from IDLE or from the
   // last (ACCESS) cycle of the previous one, so there is never more than one
   // APB transfer in flight; the SETUP/ACCESS sequences run unconditionally.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE, RENABLE, WENABLE: begin
            if (valid && !Hwrite)     state_d = READ;
            else if (valid && Hwrite) state_d = WWAIT;
            else                      state_d = IDLE;
         end
         READ:    state_d = RENABLE;
         WWAIT:   state_d = WRITE;
         WRITE:   state_d = WENABLE;
         default: state_d = IDLE;
      endcase
   end

   // State register plus registered APB-side outputs, loaded from the state
   // being entered. A write spends one extra cycle in WWAIT so that the
   // write data, which arrives in the AHB data phase, can be captured.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q     <= IDLE;
         pselx_q     <= 3'b000;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= 32'h0;
         pwdata_q    <= 32'h0;
         addrHold_q  <= 32'h0;
         selHold_q   <= 3'b000;
         hreadyout_q <= 1'b1;
      end else begin
         state_q <= state_d;
         case (state_d)
            READ: begin
               paddr_q     <= Haddr;
               pselx_q     <= selx;
               pwrite_q    <= 1'b0;
               penable_q   <= 1'b0;
               hreadyout_q <= 1'b0;
            end
            RENABLE, WENABLE: begin
               penable_q   <= 1'b1;
               hreadyout_q <= 1'b1;
            end
            WWAIT: begin
               addrHold_q  <= Haddr;
               selHold_q   <= selx;
               pselx_q     <= 3'b000;
               penable_q   <= 1'b0;
               hreadyout_q <= 1'b0;
            end
            WRITE: begin
               paddr_q     <= addrHold_q;
               pselx_q     <= selHold_q;
               pwdata_q    <= Hwdata;
               pwrite_q    <= 1'b1;
               penable_q   <= 1'b0;
               hreadyout_q <= 1'b0;
            end
            default: begin
               pselx_q     <= 3'b000;
               penable_q   <= 1'b0;
               hreadyout_q <= 1'b1;
            end
         endcase
      end
   end

   assign Pselx     = pselx_q;
   assign Penable   = penable_q;
   assign Pwrite    = pwrite_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = pwdata_q;
   assign Hreadyout = hreadyout_q;
   assign Hresp     = 2'b00;
   assign Hrdata    = (state_q == RENABLE) ? Prdata : 32'h0;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller
// Directed cycle table for the documented scenarios followed by random
// traffic compared against a transaction-level reference model.

module tb_apb_fsm_controller;

   logic        Hclk;
   logic        Hreset;
   logic        Hwrite;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Prdata;
   logic        Pwrite;
   logic        Penable;
   logic [2:0]  Pselx;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;

   int total = 0;
   int bad   = 0;
   bit chkEn = 1'b0;

   apb_fsm_controller dut (
      .Hclk      (Hclk),
      .Hreset    (Hreset),
      .Hwrite    (Hwrite),
      .Hreadyin  (Hreadyin),
      .Htrans    (Htrans),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Prdata    (Prdata),
      .Pwrite    (Pwrite),
      .Penable   (Penable),
      .Pselx     (Pselx),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      Hclk = 1'b0;
      forever #5 Hclk = ~Hclk;
   end

   // One cycle of directed stimulus plus the outputs expected after the edge.
   typedef struct {
      logic        rst;
      logic        hwrite;
      logic        hreadyin;
      logic [1:0]  htrans;
      logic [31:0] haddr;
      logic [31:0] hwdata;
      logic [31:0] prdata;
      logic [2:0]  sel;
      logic        en;
      logic        wr;
      logic        rdy;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] hrdata;
   } vec_t;

   vec_t vecs[$];

   // Reference model: a transfer is a list of per-cycle bus steps queued at
   // acceptance time; a new transfer is taken only when nothing is queued.
   typedef struct packed {
      logic [2:0]  sel;
      logic        en;
      logic        rdy;
      logic        capAddr;
      logic        capWrite;
      logic        wr;
      logic        capWdata;
      logic        rdAcc;
      logic [31:0] addr;
   } step_t;

   typedef struct packed {
      logic [2:0]  sel;
      logic        en;
      logic        rdy;
      logic        wr;
      logic        rdAcc;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   step_t steps[$];
   bus_t  cur;

   logic [2:0]  prevSel;
   logic [31:0] prevAddr;
   logic        prevEn;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic hw, input logic hr, input logic [1:0] ht,
                                input logic [31:0] ha, input logic [31:0] hwd, input logic [31:0] prd);
      Hreset   = rst;
      Hwrite   = hw;
      Hreadyin = hr;
      Htrans   = ht;
      Haddr    = ha;
      Hwdata   = hwd;
      Prdata   = prd;
   endtask

   task automatic addVec(input logic rst, input logic hw, input logic hr, input logic [1:0] ht,
                         input logic [31:0] ha, input logic [31:0] hwd, input logic [31:0] prd,
                         input logic [2:0] sel, input logic en, input logic wr, input logic rdy,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] hrd);
      vec_t v;
      v.rst = rst; v.hwrite = hw; v.hreadyin = hr; v.htrans = ht;
      v.haddr = ha; v.hwdata = hwd; v.prdata = prd;
      v.sel = sel; v.en = en; v.wr = wr; v.rdy = rdy;
      v.addr = addr; v.wdata = wdata; v.hrdata = hrd;
      vecs.push_back(v);
   endtask

   function automatic logic [2:0] slaveOf(input logic [31:0] a);
      int top;
      top = int'(a[31:26]);
      if (top >= 32 && top <= 34) return 3'(1 << (top - 32));
      return 3'b000;
   endfunction

   // Model update at each rising edge from the inputs the DUT samples there.
   always @(posedge Hclk) begin
      step_t s;
      logic [2:0] sel;
      if (Hreset) begin
         steps.delete();
         cur = '0;
         cur.rdy = 1'b1;
      end else begin
         sel = slaveOf(Haddr);
         if (steps.size() == 0 && Hreadyin && Htrans[1] && sel != 3'b000) begin
            if (!Hwrite) begin
               steps.push_back('{sel: sel, en: 1'b0, rdy: 1'b0, capAddr: 1'b1, capWrite: 1'b1,
                                 wr: 1'b0, capWdata: 1'b0, rdAcc: 1'b0, addr: Haddr});
               steps.push_back('{sel: sel, en: 1'b1, rdy: 1'b1, capAddr: 1'b0, capWrite: 1'b0,
                                 wr: 1'b0, capWdata: 1'b0, rdAcc: 1'b1, addr: 32'h0});
            end else begin
               steps.push_back('{sel: 3'b000, en: 1'b0, rdy: 1'b0, capAddr: 1'b0, capWrite: 1'b0,
                                 wr: 1'b0, capWdata: 1'b0, rdAcc: 1'b0, addr: 32'h0});
               steps.push_back('{sel: sel, en: 1'b0, rdy: 1'b0, capAddr: 1'b1, capWrite: 1'b1,
                                 wr: 1'b1, capWdata: 1'b1, rdAcc: 1'b0, addr: Haddr});
               steps.push_back('{sel: sel, en: 1'b1, rdy: 1'b1, capAddr: 1'b0, capWrite: 1'b0,
                                 wr: 1'b0, capWdata: 1'b0, rdAcc: 1'b0, addr: 32'h0});
            end
         end
         if (steps.size() > 0) begin
            s = steps.pop_front();
            cur.sel   = s.sel;
            cur.en    = s.en;
            cur.rdy   = s.rdy;
            cur.rdAcc = s.rdAcc;
            if (s.capAddr)  cur.addr  = s.addr;
            if (s.capWrite) cur.wr    = s.wr;
            if (s.capWdata) cur.wdata = Hwdata;
         end else begin
            cur.sel   = 3'b000;
            cur.en    = 1'b0;
            cur.rdy   = 1'b1;
            cur.rdAcc = 1'b0;
         end
      end
   end

   // Continuous comparison against the model plus bus invariants, mid-cycle.
   always @(negedge Hclk) begin
      if (chkEn) begin
         checkOutput("model Pselx", 32'(Pselx), 32'(cur.sel));
         checkOutput("model Penable", 32'(Penable), 32'(cur.en));
         checkOutput("model Hreadyout", 32'(Hreadyout), 32'(cur.rdy));
         checkOutput("model Pwrite", 32'(Pwrite), 32'(cur.wr));
         checkOutput("model Paddr", Paddr, cur.addr);
         checkOutput("model Pwdata", Pwdata, cur.wdata);
         checkOutput("model Hrdata", Hrdata, cur.rdAcc ? Prdata : 32'h0);
         checkOutput("Hresp okay", 32'(Hresp), 32'h0);
         if (Penable === 1'b1) begin
            checkOutput("enable follows setup",
                        {28'h0, (Pselx != 3'b000), (prevEn == 1'b0), (prevSel == Pselx), (prevAddr == Paddr)},
                        32'hF);
         end
         prevSel  = Pselx;
         prevAddr = Paddr;
         prevEn   = Penable;
      end
   end

   // Main sequence: directed table first, then random traffic.
   initial begin
      prevSel  = 3'b000;
      prevAddr = 32'h0;
      prevEn   = 1'b0;
      cur      = '0;
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);

      // rst hw hr htrans haddr hwdata prdata | sel en wr rdy paddr pwdata hrdata
      addVec(1'b1, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h0,          32'h0,          32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h0,          32'h0,          32'h0);
      addVec(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0010, 32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'hDEAD_BEEF, 32'h0,          3'b001, 1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0,          3'b001, 1'b1, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0,          3'b000, 1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b10, 32'h8400_0004, 32'h0,          32'h0,          3'b010, 1'b0, 1'b0, 1'b0, 32'h8400_0004, 32'hDEAD_BEEF, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'hCAFE_F00D, 3'b010, 1'b1, 1'b0, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'hCAFE_F00D, 3'b000, 1'b0, 1'b0, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF, 32'h0);
      addVec(1'b0, 1'b1, 1'b1, 2'b10, 32'h8800_0000, 32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b0, 32'h8400_0004, 32'hDEAD_BEEF, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b10, 32'h8000_0008, 32'h0000_1234, 32'h0,          3'b100, 1'b0, 1'b1, 1'b0, 32'h8800_0000, 32'h0000_1234, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b10, 32'h8000_0008, 32'h0000_1234, 32'h0,          3'b100, 1'b1, 1'b1, 1'b1, 32'h8800_0000, 32'h0000_1234, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b10, 32'h8000_0008, 32'h0000_1234, 32'h0,          3'b001, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h0000_1234, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h55AA_55AA, 3'b001, 1'b1, 1'b0, 1'b1, 32'h8000_0008, 32'h0000_1234, 32'h55AA_55AA);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h0000_1234, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h0000_1234, 32'h0);
      addVec(1'b0, 1'b1, 1'b1, 2'b00, 32'h8000_0000, 32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h0000_1234, 32'h0);
      addVec(1'b0, 1'b0, 1'b0, 2'b10, 32'h8400_0000, 32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h0000_1234, 32'h0);
      addVec(1'b0, 1'b1, 1'b1, 2'b10, 32'h8400_0020, 32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h0000_1234, 32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0BAD_F00D, 32'h0,          3'b010, 1'b0, 1'b1, 1'b0, 32'h8400_0020, 32'h0BAD_F00D, 32'h0);
      addVec(1'b1, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h0,          32'h0,          32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h0,          32'h0,          32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b11, 32'h8800_0040, 32'h0,          32'h0,          3'b100, 1'b0, 1'b0, 1'b0, 32'h8800_0040, 32'h0,          32'h0);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0000_0001, 3'b100, 1'b1, 1'b0, 1'b1, 32'h8800_0040, 32'h0,          32'h0000_0001);
      addVec(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          32'h0,          3'b000, 1'b0, 1'b0, 1'b1, 32'h8800_0040, 32'h0,          32'h0);

      @(posedge Hclk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].hwrite, vecs[i].hreadyin, vecs[i].htrans,
                       vecs[i].haddr, vecs[i].hwdata, vecs[i].prdata);
         @(posedge Hclk);
         #1;
         checkOutput($sformatf("vec%0d Pselx", i), 32'(Pselx), 32'(vecs[i].sel));
         checkOutput($sformatf("vec%0d Penable", i), 32'(Penable), 32'(vecs[i].en));
         checkOutput($sformatf("vec%0d Pwrite", i), 32'(Pwrite), 32'(vecs[i].wr));
         checkOutput($sformatf("vec%0d Hreadyout", i), 32'(Hreadyout), 32'(vecs[i].rdy));
         checkOutput($sformatf("vec%0d Paddr", i), Paddr, vecs[i].addr);
         checkOutput($sformatf("vec%0d Pwdata", i), Pwdata, vecs[i].wdata);
         checkOutput($sformatf("vec%0d Hrdata", i), Hrdata, vecs[i].hrdata);
         if (i == 0) chkEn = 1'b1;
      end

      $display("[TB] directed table applied, starting random traffic");
      for (int c = 0; c < 800; c++) begin
         logic [5:0]  top;
         int          pick;
         pick = $urandom_range(0, 4);
         if (pick <= 2)      top = 6'(32 + pick);
         else if (pick == 3) top = 6'h23;
         else                top = 6'($urandom);
         applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 7) != 0),
                       2'($urandom), {top, 26'($urandom)}, $urandom, $urandom);
         @(posedge Hclk);
         #1;
      end

      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
      repeat (4) begin
         @(posedge Hclk);
         #1;
      end
      @(negedge Hclk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
